crossbar_issue_ctrl: RTL and testbench
======================================

// Module: crossbar_issue_ctrl
// PURPOSE
//  Per-stage sequencer in front of the action crossbar. Buffers PHVs from the previous stage and VLIW action words from the lookup engine.
//  Pairs them in arrival order and issues each pair to the crossbar in one cycle, only when the crossbar and the ALUs can both accept it.
//  This guarantees the crossbar never enters its HALT state, where it would drop beats.
//  Also provides a bypass mode, per-stage counters and sticky error flags.
// PARAMETERS
//  STAGE_ID      0     stage index; used only in sim messages
//  NUM_PER_TYPE  8     containers per type (6B/4B/2B)
//  PHV_LEN       48*NUM_PER_TYPE+32*NUM_PER_TYPE+16*NUM_PER_TYPE+256   PHV width (1024 at default)
//  ACT_LEN       25    sub-action width; 25 sub-actions per action word
//  DEPTH         8     entries per FIFO, power of 2, >=2
// PORTS
//  clk              in   1            clock
//  rst_n            in   1            async active-low reset
//  phv_in           in   PHV_LEN      PHV from previous stage
//  phv_in_valid     in   1            PHV beat valid
//  phv_ready_out    out  1            PHV FIFO can accept a beat
//  action_in        in   ACT_LEN*25   action word from lookup, in PHV order
//  action_in_valid  in   1            action beat valid; no backpressure
//  xbar_phv         out  PHV_LEN      to crossbar phv_in
//  xbar_phv_valid   out  1            to crossbar phv_in_valid
//  xbar_action      out  ACT_LEN*25   to crossbar action_in
//  xbar_action_valid out 1            to crossbar action_in_valid; equals xbar_phv_valid
//  xbar_ready       in   1            crossbar ready_out
//  alu_ready        in   1            same ready signal that drives crossbar ready_in
//  cfg_bypass       in   1            1 = issue PHVs with an all-zero action (no-op)
//  pair_cnt         out  32           issued beats, wraps at 2^32
//  stall_cnt        out  32           cycles with a pair available but not issued; saturates
//  err_orphan       out  1            sticky: action arrived while outstanding count was 0
//  err_phv_ovf      out  1            sticky: phv_in_valid while phv_ready_out was 0 (beat dropped)
// BEHAVIOUR
//  Reset: both FIFOs empty; mode=NORMAL; counters 0; errors 0; phv_ready_out=1.
//   Valid outputs are 0. Data outputs are the FIFO heads, all-zero after reset.
//  FIFOs: first-word-fall-through. A write at the edge ending cycle t is visible at the head in t+1. Minimum latency 1 cycle.
//  phv_ready_out = (phv_count < DEPTH), computed from the registered count only.
//   No same-cycle pass-through: when full, a simultaneous pop does not free the slot for a push.
//  outstanding = PHVs pushed minus actions pushed; this register saturates at 0.
//   An action with outstanding==0 is discarded and sets err_orphan.
//   Action FIFO occupancy <= PHV FIFO occupancy always, so the action FIFO cannot overflow.
//  Issue gate: go = xbar_ready & alu_ready & pair_avail.
//   pair_avail in NORMAL: both FIFOs non-empty.
//   pair_avail in BYPASS: PHV FIFO non-empty.
//   xbar_phv_valid = xbar_action_valid = go (combinational from registers and the two readies).
//   Pop both heads (BYPASS: PHV head only) at the edge when go=1.
//   xbar_action = action head; forced to 0 in BYPASS.
//  Mode FSM:
//   NORMAL -> DRAIN when cfg_bypass=1.
//   DRAIN: pairs keep issuing; no new PHV accepted (phv_ready_out=0).
//    -> BYPASS when both FIFOs are empty and outstanding==0.
//    -> NORMAL if cfg_bypass drops while in DRAIN.
//   BYPASS -> NORMAL when cfg_bypass=0 and PHV FIFO empty.
//   In BYPASS, action_in is ignored and err_orphan is not evaluated.
//  Counters: pair_cnt += go. stall_cnt += (pair_avail & ~go).
//  Simultaneous push/pop on the same FIFO: count unchanged; pointers both advance.
//  Reset mid-operation: all buffered beats are discarded with no drain, and the output valids drop immediately.
// STRUCTURE
//  Package rmt_stage_pkg holds:
//   localparams NUM_SUB_ACT=25 and ACT_W=ACT_LEN*NUM_SUB_ACT;
//   PHV_LEN derivation;
//   mode encoding NORMAL=2'd0, DRAIN=2'd1, BYPASS=2'd2.
//  One sub-module: xbar_sync_fifo (WIDTH, DEPTH; FWFT; wr_en/rd_en/full/empty/count).
//   Instantiated twice, for PHV and for action.
// TESTING
//  1) PHV A at cycle 0, action A at cycle 3, both readies 1 -> one valid pulse at cycle 4 carrying A/A; pair_cnt=1.
//  2) 3 PHVs back-to-back, then 3 actions back-to-back -> 3 consecutive issues, order preserved; outstanding returns to 0.
//  3) Pair ready, alu_ready=0 for 5 cycles -> no valid; stall_cnt=5; issue occurs in the first cycle with alu_ready=1.
//  4) Push 8 PHVs with no actions -> phv_ready_out=0. A 9th phv_in_valid sets err_phv_ovf; FIFO contents unchanged.
//  5) action_in_valid with no PHV pending -> err_orphan=1, no issue, action FIFO empty.
//  6) 2 pairs queued, cfg_bypass=1 -> both issue with their actions during DRAIN, then BYPASS.
//     Subsequent PHV issues with xbar_action=0. Assert rst_n mid-stream -> valids drop and counters clear.

Source files
------------

// File: rtl/rmt_stage_pkg.sv
// Shared definitions for the RMT stage front-end.
//   NUM_SUB_ACT  sub-actions carried by one VLIW action word
//   ACT_W        action word width at the default sub-action width
//   phv_len()    PHV width derived from containers per type (6B/4B/2B + 256b metadata)
//   mode_e       issue controller operating mode
package rmt_stage_pkg;

  localparam int unsigned NUM_SUB_ACT = 25;
  localparam int unsigned ACT_LEN_DEF = 25;
  localparam int unsigned ACT_W       = ACT_LEN_DEF * NUM_SUB_ACT;

  function automatic int unsigned phv_len(input int unsigned num_per_type);
    return 48 * num_per_type + 32 * num_per_type + 16 * num_per_type + 256;
  endfunction

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_DRAIN  = 2'd1,
    MODE_BYPASS = 2'd2
  } mode_e;

endpackage

// File: rtl/xbar_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
//   clk, rst_n   clock, async active-low reset (storage cleared so the head reads 0)
//   wr_en/wr_data  push; ignored when full
//   rd_en/rd_data  pop; rd_data is always the current head
//   full/empty/count  occupancy from registered state only
module xbar_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_wr, do_rd;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Full is registered, so a pop in the same cycle never makes room for a push.
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_wr) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_rd) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_wr, do_rd})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/crossbar_issue_ctrl.sv
// Per-stage sequencer in front of the action crossbar. Buffers PHVs and VLIW
// action words, pairs them in arrival order and issues a pair only when both
// the crossbar and the ALUs are ready, so the crossbar never halts.
//   phv_in/phv_in_valid/phv_ready_out       PHV input with backpressure
//   action_in/action_in_valid               action input, no backpressure
//   xbar_phv/xbar_action (+ _valid)         issued pair to the crossbar
//   xbar_ready, alu_ready                   downstream readies
//   cfg_bypass                              issue PHVs with a no-op action
//   pair_cnt, stall_cnt                     issued beats (wraps), stalled cycles (saturates)
//   err_orphan, err_phv_ovf                 sticky error flags
module crossbar_issue_ctrl
  import rmt_stage_pkg::*;
#(
  parameter int unsigned STAGE_ID     = 0,
  parameter int unsigned NUM_PER_TYPE = 8,
  parameter int unsigned PHV_LEN      = phv_len(NUM_PER_TYPE),
  parameter int unsigned ACT_LEN      = 25,
  parameter int unsigned DEPTH        = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [PHV_LEN-1:0]             phv_in,
  input  logic                           phv_in_valid,
  output logic                           phv_ready_out,
  input  logic [ACT_LEN*NUM_SUB_ACT-1:0] action_in,
  input  logic                           action_in_valid,
  output logic [PHV_LEN-1:0]             xbar_phv,
  output logic                           xbar_phv_valid,
  output logic [ACT_LEN*NUM_SUB_ACT-1:0] xbar_action,
  output logic                           xbar_action_valid,
  input  logic                           xbar_ready,
  input  logic                           alu_ready,
  input  logic                           cfg_bypass,
  output logic [31:0]                    pair_cnt,
  output logic [31:0]                    stall_cnt,
  output logic                           err_orphan,
  output logic                           err_phv_ovf
);

  localparam int unsigned AW = ACT_LEN * NUM_SUB_ACT;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  mode_e mode_q, mode_d;

  logic [PHV_LEN-1:0] phv_head;
  logic [AW-1:0]      act_head;
  logic               phv_full, phv_empty, act_full, act_empty;
  logic [CW-1:0]      phv_count, act_count;
  logic [CW-1:0]      outst_q, outst_d;
  logic               phv_push, act_push, act_pop, orphan;
  logic               pair_avail, go;
  logic [31:0]        pair_cnt_q, stall_cnt_q;
  logic               err_orphan_q, err_phv_ovf_q;

  xbar_sync_fifo #(.WIDTH(PHV_LEN), .DEPTH(DEPTH)) u_phv_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (phv_push),
    .wr_data (phv_in),
    .rd_en   (go),
    .rd_data (phv_head),
    .full    (phv_full),
    .empty   (phv_empty),
    .count   (phv_count)
  );

  xbar_sync_fifo #(.WIDTH(AW), .DEPTH(DEPTH)) u_act_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (act_push),
    .wr_data (action_in),
    .rd_en   (act_pop),
    .rd_data (act_head),
    .full    (act_full),
    .empty   (act_empty),
    .count   (act_count)
  );

  assign phv_ready_out = ~phv_full & (mode_q != MODE_DRAIN);
  assign phv_push      = phv_in_valid & phv_ready_out;

  // An action is only buffered if a PHV is waiting for it; this keeps the
  // action FIFO no fuller than the PHV FIFO.
  assign orphan   = action_in_valid & (mode_q != MODE_BYPASS) & (outst_q == '0);
  assign act_push = action_in_valid & (mode_q != MODE_BYPASS) & (outst_q != '0);

  assign pair_avail = (mode_q == MODE_BYPASS) ? ~phv_empty : (~phv_empty & ~act_empty);
  assign go         = xbar_ready & alu_ready & pair_avail;
  assign act_pop    = go & (mode_q != MODE_BYPASS);

  assign xbar_phv          = phv_head;
  assign xbar_action       = (mode_q == MODE_BYPASS) ? '0 : act_head;
  assign xbar_phv_valid    = go;
  assign xbar_action_valid = go;

  assign pair_cnt    = pair_cnt_q;
  assign stall_cnt   = stall_cnt_q;
  assign err_orphan  = err_orphan_q;
  assign err_phv_ovf = err_phv_ovf_q;

  // PHVs accepted in BYPASS never expect an action, so they are not counted.
  always_comb begin
    outst_d = outst_q;
    case ({phv_push & (mode_q == MODE_NORMAL), act_push})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase
  end

  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      MODE_NORMAL: if (cfg_bypass) mode_d = MODE_DRAIN;
      MODE_DRAIN: begin
        if (!cfg_bypass)                                    mode_d = MODE_NORMAL;
        else if (phv_empty && act_empty && outst_q == '0)  mode_d = MODE_BYPASS;
      end
      MODE_BYPASS: if (!cfg_bypass && phv_empty) mode_d = MODE_NORMAL;
      default:     mode_d = MODE_NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q        <= MODE_NORMAL;
      outst_q       <= '0;
      pair_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      err_orphan_q  <= 1'b0;
      err_phv_ovf_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      outst_q    <= outst_d;
      pair_cnt_q <= pair_cnt_q + 32'(go);
      if (pair_avail && !go && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (orphan) err_orphan_q <= 1'b1;
      if (phv_in_valid && !phv_ready_out) err_phv_ovf_q <= 1'b1;
    end
  end

  a_act_le_phv: assert property (@(posedge clk) disable iff (!rst_n)
                                 (act_count <= phv_count) && !(act_push && act_full))
    else $error("stage %0d: action FIFO ahead of PHV FIFO", STAGE_ID);

endmodule

// File: tb/tb_crossbar_issue_ctrl.sv
module tb_crossbar_issue_ctrl;

  localparam int unsigned PW  = 1024;
  localparam int unsigned AWD = 625;

  logic            clk;
  logic            rst_n;
  logic [PW-1:0]   phv_in;
  logic            phv_in_valid;
  logic            phv_ready_out;
  logic [AWD-1:0]  action_in;
  logic            action_in_valid;
  logic [PW-1:0]   xbar_phv;
  logic            xbar_phv_valid;
  logic [AWD-1:0]  xbar_action;
  logic            xbar_action_valid;
  logic            xbar_ready;
  logic            alu_ready;
  logic            cfg_bypass;
  logic [31:0]     pair_cnt;
  logic [31:0]     stall_cnt;
  logic            err_orphan;
  logic            err_phv_ovf;

  crossbar_issue_ctrl #(
    .STAGE_ID(0), .NUM_PER_TYPE(8), .ACT_LEN(25), .DEPTH(8)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .phv_in            (phv_in),
    .phv_in_valid      (phv_in_valid),
    .phv_ready_out     (phv_ready_out),
    .action_in         (action_in),
    .action_in_valid   (action_in_valid),
    .xbar_phv          (xbar_phv),
    .xbar_phv_valid    (xbar_phv_valid),
    .xbar_action       (xbar_action),
    .xbar_action_valid (xbar_action_valid),
    .xbar_ready        (xbar_ready),
    .alu_ready         (alu_ready),
    .cfg_bypass        (cfg_bypass),
    .pair_cnt          (pair_cnt),
    .stall_cnt         (stall_cnt),
    .err_orphan        (err_orphan),
    .err_phv_ovf       (err_phv_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0]  phv;
    logic [AWD-1:0] act;
  } pair_t;

  typedef struct {
    int unsigned tag;
    int unsigned gap;        // cycles from PHV beat to action beat (>=1)
    int unsigned alu_hold;   // cycles alu_ready held low once the pair is buffered
    int unsigned exp_stall;  // expected stall_cnt increment
  } vec_t;

  pair_t          sb[$];
  logic [PW-1:0]  pend[$];
  int unsigned    passed = 0;
  int unsigned    total  = 0;
  int unsigned    exp_pair  = 0;
  int unsigned    exp_stall = 0;
  vec_t           tbl[4];

  function automatic logic [PW-1:0] mk_phv(input int unsigned t);
    logic [PW-1:0] v;
    for (int i = 0; i < 32; i++) v[i*32 +: 32] = (t * 32'h01010101) ^ 32'(i);
    return v;
  endfunction

  function automatic logic [AWD-1:0] mk_act(input int unsigned t);
    logic [AWD-1:0] v;
    for (int i = 0; i < 25; i++) v[i*25 +: 25] = 25'(t * 7 + 32'(i) + 1);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_phv(input int unsigned t, input bit bypass);
    pair_t e;
    phv_in       = mk_phv(t);
    phv_in_valid = 1'b1;
    if (bypass) begin
      e.phv = mk_phv(t);
      e.act = '0;
      sb.push_back(e);
    end else begin
      pend.push_back(mk_phv(t));
    end
  endtask

  task automatic drive_act(input int unsigned t);
    pair_t e;
    action_in       = mk_act(t);
    action_in_valid = 1'b1;
    e.phv = pend.pop_front();
    e.act = mk_act(t);
    sb.push_back(e);
  endtask

  // Scoreboard: every issued beat must match the oldest expected pair.
  always @(negedge clk) begin
    if (rst_n && xbar_phv_valid) begin
      pair_t e;
      chk("act_valid_with_phv_valid", 64'(xbar_action_valid), 64'd1);
      if (sb.size() == 0) begin
        chk("unexpected_issue", 64'(xbar_phv[31:0]), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("issue_phv", 64'(xbar_phv[63:0]), e.phv[63:0]);
        chk("issue_phv_full", 64'(xbar_phv == e.phv), 64'd1);
        chk("issue_act_full", 64'(xbar_action == e.act), 64'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{tag: 1, gap: 3, alu_hold: 0, exp_stall: 0};
    tbl[1] = '{tag: 2, gap: 1, alu_hold: 0, exp_stall: 0};
    tbl[2] = '{tag: 3, gap: 2, alu_hold: 5, exp_stall: 5};
    tbl[3] = '{tag: 4, gap: 1, alu_hold: 1, exp_stall: 1};

    rst_n = 1'b0; phv_in = '0; phv_in_valid = 1'b0; action_in = '0; action_in_valid = 1'b0;
    xbar_ready = 1'b1; alu_ready = 1'b1; cfg_bypass = 1'b0;
    #1;
    chk("rst_ready", 64'(phv_ready_out), 64'd1);
    chk("rst_valid", 64'(xbar_phv_valid), 64'd0);
    chk("rst_pair_cnt", 64'(pair_cnt), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_errs", 64'({err_orphan, err_phv_ovf}), 64'd0);
    chk("rst_heads_zero", 64'((xbar_phv == '0) && (xbar_action == '0)), 64'd1);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single pairs with varying action latency and ALU backpressure.
    for (int i = 0; i < 4; i++) begin
      drive_phv(tbl[i].tag, 1'b0);
      @(negedge clk); chk("tbl_no_issue_phv", 64'(xbar_phv_valid), 64'd0);
      tick(); phv_in_valid = 1'b0;
      for (int g = 1; g < int'(tbl[i].gap); g++) begin
        @(negedge clk); chk("tbl_no_issue_wait", 64'(xbar_phv_valid), 64'd0);
        tick();
      end
      drive_act(tbl[i].tag);
      @(negedge clk); chk("tbl_no_issue_act", 64'(xbar_phv_valid), 64'd0);
      tick(); action_in_valid = 1'b0;
      if (tbl[i].alu_hold > 0) alu_ready = 1'b0;
      for (int h = 0; h < int'(tbl[i].alu_hold); h++) begin
        @(negedge clk); chk("tbl_stalled", 64'(xbar_phv_valid), 64'd0);
        tick();
      end
      alu_ready = 1'b1;
      @(negedge clk); chk("tbl_issue_cycle", 64'(xbar_phv_valid), 64'd1);
      exp_pair++; exp_stall += tbl[i].exp_stall;
      tick();
      @(negedge clk);
      chk("tbl_pair_cnt", 64'(pair_cnt), 64'(exp_pair));
      chk("tbl_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
      chk("tbl_single_pulse", 64'(xbar_phv_valid), 64'd0);
      tick();
    end

    // Three PHVs then three actions: consecutive in-order issues.
    for (int k = 0; k < 3; k++) begin
      drive_phv(10 + k, 1'b0); @(negedge clk); tick();
    end
    phv_in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_act(10 + k);
      @(negedge clk); chk("b2b_valid", 64'(xbar_phv_valid), 64'(k > 0));
      tick();
    end
    action_in_valid = 1'b0;
    @(negedge clk); chk("b2b_last_issue", 64'(xbar_phv_valid), 64'd1);
    tick();
    exp_pair += 3;
    @(negedge clk); chk("b2b_pair_cnt", 64'(pair_cnt), 64'(exp_pair));
    tick();

    // Action with nothing outstanding: dropped, flagged, never issued.
    action_in = mk_act(99); action_in_valid = 1'b1;
    @(negedge clk); tick(); action_in_valid = 1'b0;
    @(negedge clk); chk("orphan_flag", 64'(err_orphan), 64'd1);
    tick();
    drive_phv(20, 1'b0); @(negedge clk); tick(); phv_in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("orphan_not_buffered", 64'(xbar_phv_valid), 64'd0);
      tick();
    end
    drive_act(20); @(negedge clk); tick(); action_in_valid = 1'b0;
    @(negedge clk); chk("orphan_then_pair", 64'(xbar_phv_valid), 64'd1);
    exp_pair++;
    tick();

    // Fill the PHV FIFO, overflow it, then confirm contents intact.
    for (int k = 0; k < 8; k++) begin
      drive_phv(30 + k, 1'b0);
      @(negedge clk); chk("fill_ready", 64'(phv_ready_out), 64'd1);
      tick();
    end
    phv_in_valid = 1'b0;
    @(negedge clk);
    chk("full_not_ready", 64'(phv_ready_out), 64'd0);
    chk("full_no_ovf_yet", 64'(err_phv_ovf), 64'd0);
    tick();
    phv_in = mk_phv(77); phv_in_valid = 1'b1;
    @(negedge clk); tick(); phv_in_valid = 1'b0;
    @(negedge clk); chk("ovf_flag", 64'(err_phv_ovf), 64'd1);
    tick();
    for (int k = 0; k < 8; k++) begin
      drive_act(30 + k); @(negedge clk); tick();
    end
    action_in_valid = 1'b0;
    tick(); tick();
    exp_pair += 8;
    @(negedge clk);
    chk("full_pair_cnt", 64'(pair_cnt), 64'(exp_pair));
    chk("full_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    tick();

    // Two pairs queued behind a busy crossbar, then switch to bypass.
    xbar_ready = 1'b0;
    drive_phv(40, 1'b0); @(negedge clk); tick();
    drive_phv(41, 1'b0); @(negedge clk); tick(); phv_in_valid = 1'b0;
    drive_act(40); @(negedge clk); tick();
    drive_act(41); @(negedge clk); tick(); action_in_valid = 1'b0;
    cfg_bypass = 1'b1;
    @(negedge clk); chk("drain_held", 64'(xbar_phv_valid), 64'd0);
    tick();
    xbar_ready = 1'b1;
    @(negedge clk);
    chk("drain_not_ready", 64'(phv_ready_out), 64'd0);
    chk("drain_issue0", 64'(xbar_phv_valid), 64'd1);
    tick();
    @(negedge clk); chk("drain_issue1", 64'(xbar_phv_valid), 64'd1);
    tick();
    @(negedge clk);
    chk("drain_done", 64'(xbar_phv_valid), 64'd0);
    chk("drain_still_not_ready", 64'(phv_ready_out), 64'd0);
    tick();
    exp_pair += 2; exp_stall += 2;
    @(negedge clk);
    chk("bypass_ready", 64'(phv_ready_out), 64'd1);
    chk("drain_pair_cnt", 64'(pair_cnt), 64'(exp_pair));
    chk("drain_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    drive_phv(50, 1'b1);
    action_in = mk_act(51); action_in_valid = 1'b1;
    tick(); phv_in_valid = 1'b0; action_in_valid = 1'b0;
    @(negedge clk); chk("bypass_issue", 64'(xbar_phv_valid), 64'd1);
    tick();

    // Queue two bypass PHVs, then reset while one is being issued.
    xbar_ready = 1'b0;
    drive_phv(60, 1'b1); tick();
    drive_phv(61, 1'b1); tick(); phv_in_valid = 1'b0;
    xbar_ready = 1'b1;
    #2;
    chk("pre_reset_valid", 64'(xbar_phv_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_valid_drop", 64'({xbar_phv_valid, xbar_action_valid}), 64'd0);
    chk("reset_pair_cnt", 64'(pair_cnt), 64'd0);
    chk("reset_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("reset_errs", 64'({err_orphan, err_phv_ovf}), 64'd0);
    sb.delete(); pend.delete();
    exp_pair = 0; exp_stall = 0;
    cfg_bypass = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_heads", 64'((xbar_phv == '0) && (xbar_action == '0)), 64'd1);
    chk("post_reset_ready", 64'(phv_ready_out), 64'd1);
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("post_reset_quiet", 64'(xbar_phv_valid), 64'd0);
      tick();
    end
    drive_phv(70, 1'b0); @(negedge clk); tick(); phv_in_valid = 1'b0;
    drive_act(70); @(negedge clk); tick(); action_in_valid = 1'b0;
    @(negedge clk); chk("post_reset_issue", 64'(xbar_phv_valid), 64'd1);
    tick();
    @(negedge clk); chk("post_reset_pair_cnt", 64'(pair_cnt), 64'd1);
    tick(); tick();

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
